mem_stage_wb_ctrl: RTL and testbench

//  Consumer side of the EX/MEM pipeline register: the MEM stage plus the MEM/WB register.
//  - Resolves branches from EX/MEM fields and issues the PC redirect / pipeline flush.
//  - Runs a req/ack handshake to a multi-cycle data memory and stalls upstream while an access is pending.
//  - Registers results for write-back.

---
 rtl/cpu_pipe_pkg.sv | 13 +
 rtl/mem_stage_wb_ctrl_if.sv | 23 ++
 rtl/mem_wb_reg.sv | 55 +++++
 rtl/mem_stage_wb_ctrl.sv | 133 +++++++++++++
 tb/tb_mem_stage_wb_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared types and default widths for the MEM stage / MEM-WB slice of the CPU pipeline.
package cpu_pipe_pkg;

  localparam int CP_XLEN    = 64;
  localparam int CP_RD_W    = 5;
  localparam int CP_TIMEOUT = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_wb_ctrl_if.sv
// Data memory request/acknowledge bus between the MEM stage (master) and the memory (slave).
interface mem_stage_wb_ctrl_if
  import cpu_pipe_pkg::*;
#(
  parameter int XLEN = CP_XLEN
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: reset clears, stall inserts a bubble, otherwise loads.
module mem_wb_reg
  import cpu_pipe_pkg::*;
#(
  parameter int XLEN = CP_XLEN,
  parameter int RD_W = CP_RD_W
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [XLEN-1:0] readdata_next,
  input  logic [XLEN-1:0] alu_result_next,
  input  logic [RD_W-1:0] rd_next,
  input  logic            memtoreg_next,
  input  logic            regwrite_next,
  output logic [XLEN-1:0] wb_readdata,
  output logic [XLEN-1:0] wb_alu_result,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_memtoreg,
  output logic            wb_regwrite
);

  logic [XLEN-1:0] readdata_reg;
  logic [XLEN-1:0] alu_result_reg;
  logic [RD_W-1:0] rd_reg;
  logic            memtoreg_reg;
  logic            regwrite_reg;

  // A bubble only kills the control bits; data fields keep their old contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_reg   <= '0;
      alu_result_reg <= '0;
      rd_reg         <= '0;
      memtoreg_reg   <= 1'b0;
      regwrite_reg   <= 1'b0;
    end else if (stall) begin
      memtoreg_reg   <= 1'b0;
      regwrite_reg   <= 1'b0;
    end else begin
      readdata_reg   <= readdata_next;
      alu_result_reg <= alu_result_next;
      rd_reg         <= rd_next;
      memtoreg_reg   <= memtoreg_next;
      regwrite_reg   <= regwrite_next;
    end
  end

  assign wb_readdata   = readdata_reg;
  assign wb_alu_result = alu_result_reg;
  assign wb_rd         = rd_reg;
  assign wb_memtoreg   = memtoreg_reg;
  assign wb_regwrite   = regwrite_reg;

endmodule

// File: rtl/mem_stage_wb_ctrl.sv
// MEM stage: branch resolution, data-memory req/ack handshake with timeout, and MEM/WB register.
module mem_stage_wb_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int XLEN    = CP_XLEN,
  parameter int RD_W    = CP_RD_W,
  parameter int TIMEOUT = CP_TIMEOUT
)(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] exm_adderout,
  input  logic            exm_zero,
  input  logic [XLEN-1:0] exm_alu_result,
  input  logic [XLEN-1:0] exm_writedata,
  input  logic [RD_W-1:0] exm_rd,
  input  logic            exm_branch,
  input  logic            exm_memread,
  input  logic            exm_memwrite,
  input  logic            exm_memtoreg,
  input  logic            exm_regwrite,
  input  logic            exm_brinv,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target,
  output logic            stall_o,
  mem_stage_wb_ctrl_if.master mem,
  output logic            mem_err,
  output logic [XLEN-1:0] wb_readdata,
  output logic [XLEN-1:0] wb_alu_result,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_memtoreg,
  output logic            wb_regwrite
);

  localparam int CNT_W = $clog2(TIMEOUT);

  mem_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic            mem_req_reg, mem_we_reg, mem_err_reg;
  logic [XLEN-1:0] mem_addr_reg, mem_wdata_reg;

  logic            memop, is_load, taken, timeout, done;
  logic [XLEN-1:0] readdata_next;

  assign memop   = exm_memread | exm_memwrite;
  assign is_load = exm_memread & ~exm_memwrite;   // store wins when both are set
  assign taken   = exm_branch & (exm_brinv ? ~exm_zero : exm_zero);
  assign timeout = (state_reg == ACCESS) & ~mem.mem_ack & (cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (memop) state_next = ACCESS;
      ACCESS:  if (mem.mem_ack | timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_o     = 1'b0;
    pc_redirect = 1'b0;
    done        = 1'b0;
    case (state_reg)
      IDLE: begin
        stall_o     = memop;
        pc_redirect = taken;
      end
      ACCESS: begin
        done    = mem.mem_ack | timeout;
        stall_o = ~done;
      end
      default: ;
    endcase
  end

  // Request and its address/data are captured once on entry to ACCESS and held until completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_err_reg   <= 1'b0;
      cnt_reg       <= '0;
    end else if (state_reg == IDLE) begin
      if (memop) begin
        mem_req_reg   <= 1'b1;
        mem_we_reg    <= exm_memwrite;
        mem_addr_reg  <= exm_alu_result;
        mem_wdata_reg <= exm_writedata;
        cnt_reg       <= '0;
      end
    end else begin
      if (done) mem_req_reg <= 1'b0;
      else      cnt_reg     <= cnt_reg + CNT_W'(1);
      if (timeout) mem_err_reg <= 1'b1;
    end
  end

  // A timed-out load completes with zero data.
  assign readdata_next = ((state_reg == ACCESS) & is_load & mem.mem_ack) ? mem.mem_rdata : '0;

  assign pc_target     = exm_adderout;
  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_wdata = mem_wdata_reg;
  assign mem_err       = mem_err_reg;

  mem_wb_reg #(
    .XLEN (XLEN),
    .RD_W (RD_W)
  ) u_mem_wb_reg (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall_o),
    .readdata_next   (readdata_next),
    .alu_result_next (exm_alu_result),
    .rd_next         (exm_rd),
    .memtoreg_next   (exm_memtoreg),
    .regwrite_next   (exm_regwrite),
    .wb_readdata     (wb_readdata),
    .wb_alu_result   (wb_alu_result),
    .wb_rd           (wb_rd),
    .wb_memtoreg     (wb_memtoreg),
    .wb_regwrite     (wb_regwrite)
  );

endmodule

// File: tb/tb_mem_stage_wb_ctrl.sv
// Randomized bench for mem_stage_wb_ctrl with a transaction-level reference model and directed pins.
module tb_mem_stage_wb_ctrl;
  import cpu_pipe_pkg::*;

  localparam int XLEN = 64;
  localparam int RD_W = 5;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [XLEN-1:0] exm_adderout, exm_alu_result, exm_writedata;
  logic [RD_W-1:0] exm_rd;
  logic exm_zero, exm_branch, exm_memread, exm_memwrite, exm_memtoreg, exm_regwrite, exm_brinv;
  logic pc_redirect, stall_o, mem_err, wb_memtoreg, wb_regwrite;
  logic [XLEN-1:0] pc_target, wb_readdata, wb_alu_result;
  logic [RD_W-1:0] wb_rd;

  mem_stage_wb_ctrl_if #(.XLEN(XLEN)) mem_bus ();

  mem_stage_wb_ctrl #(.XLEN(XLEN), .RD_W(RD_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .exm_adderout(exm_adderout), .exm_zero(exm_zero), .exm_alu_result(exm_alu_result),
    .exm_writedata(exm_writedata), .exm_rd(exm_rd), .exm_branch(exm_branch),
    .exm_memread(exm_memread), .exm_memwrite(exm_memwrite), .exm_memtoreg(exm_memtoreg),
    .exm_regwrite(exm_regwrite), .exm_brinv(exm_brinv),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .stall_o(stall_o),
    .mem(mem_bus), .mem_err(mem_err),
    .wb_readdata(wb_readdata), .wb_alu_result(wb_alu_result), .wb_rd(wb_rd),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite)
  );

  int checks = 0;
  int failures = 0;
  int stall_seen = 0;
  int req_seen = 0;
  bit store_dir = 0;

  // Reference model: an outstanding access is "busy" for some number of waited cycles.
  bit              m_busy, m_we, m_err, m_wb_mtr, m_wb_rw;
  int              m_j;
  logic [XLEN-1:0] m_addr, m_wdata, m_wb_rdata, m_wb_alu;
  logic [RD_W-1:0] m_wb_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_done();
    return m_busy && (mem_bus.mem_ack || m_j == TMO - 1);
  endfunction

  function automatic bit m_stall();
    return m_busy ? !m_done() : (exm_memread || exm_memwrite);
  endfunction

  task automatic model_clear();
    m_busy = 0; m_we = 0; m_err = 0; m_j = 0; m_addr = '0; m_wdata = '0;
    m_wb_rdata = '0; m_wb_alu = '0; m_wb_rd = '0; m_wb_mtr = 0; m_wb_rw = 0;
  endtask

  task automatic model_update();
    bit d, st;
    if (reset) begin
      model_clear();
    end else begin
      d  = m_done();
      st = m_stall();
      if (st) begin
        m_wb_mtr = 0; m_wb_rw = 0;
      end else begin
        m_wb_rdata = (d && mem_bus.mem_ack && exm_memread && !exm_memwrite) ? mem_bus.mem_rdata : '0;
        m_wb_alu = exm_alu_result; m_wb_rd = exm_rd;
        m_wb_mtr = exm_memtoreg;   m_wb_rw = exm_regwrite;
      end
      if (m_busy) begin
        if (d) begin
          if (!mem_bus.mem_ack) m_err = 1;
          m_busy = 0;
        end else m_j++;
      end else if (exm_memread || exm_memwrite) begin
        m_busy = 1; m_j = 0; m_we = exm_memwrite;
        m_addr = exm_alu_result; m_wdata = exm_writedata;
      end
    end
  endtask

  task automatic compare_all();
    bit tk;
    tk = exm_branch && (exm_brinv ? !exm_zero : exm_zero);
    chk("pc_redirect", 64'(pc_redirect), 64'(tk && !m_busy));
    chk("pc_target", pc_target, exm_adderout);
    chk("stall_o", 64'(stall_o), 64'(m_stall()));
    chk("mem_req", 64'(mem_bus.mem_req), 64'(m_busy));
    chk("mem_we", 64'(mem_bus.mem_we), 64'(m_we));
    chk("mem_addr", mem_bus.mem_addr, m_addr);
    chk("mem_wdata", mem_bus.mem_wdata, m_wdata);
    chk("mem_err", 64'(mem_err), 64'(m_err));
    chk("wb_readdata", wb_readdata, m_wb_rdata);
    chk("wb_alu_result", wb_alu_result, m_wb_alu);
    chk("wb_rd", 64'(wb_rd), 64'(m_wb_rd));
    chk("wb_memtoreg", 64'(wb_memtoreg), 64'(m_wb_mtr));
    chk("wb_regwrite", 64'(wb_regwrite), 64'(m_wb_rw));
    if (stall_o) stall_seen++;
    if (mem_bus.mem_req) req_seen++;
    if (store_dir && mem_bus.mem_req) begin
      chk("store_we", 64'(mem_bus.mem_we), 64'd1);
      chk("store_addr", mem_bus.mem_addr, 64'h80);
      chk("store_wdata", mem_bus.mem_wdata, 64'h55);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_instr(input logic br, input logic brinv, input logic zero,
                           input logic mr, input logic mw, input logic mtr, input logic rw,
                           input logic [63:0] alu, input logic [63:0] wd,
                           input logic [63:0] adder, input logic [4:0] rd);
    exm_branch = br; exm_brinv = brinv; exm_zero = zero;
    exm_memread = mr; exm_memwrite = mw; exm_memtoreg = mtr; exm_regwrite = rw;
    exm_alu_result = alu; exm_writedata = wd; exm_adderout = adder; exm_rd = rd;
  endtask

  // Runs the current instruction to completion; ack arrives on waited cycle lat-1 (bounded by TMO).
  task automatic run(input int lat, input logic [63:0] rdata, input bit noise);
    string kind;
    mem_bus.mem_ack = noise && ($urandom_range(0, 3) == 0);
    mem_bus.mem_rdata = {$urandom, $urandom};
    tick();
    if (exm_memread || exm_memwrite) begin
      for (int j = 0; j < TMO; j++) begin
        mem_bus.mem_ack = (j == lat - 1);
        mem_bus.mem_rdata = mem_bus.mem_ack ? rdata : {$urandom, $urandom};
        tick();
        if (mem_bus.mem_ack || j == TMO - 1) break;
      end
    end
    mem_bus.mem_ack = 1'b0;
    kind = exm_memwrite ? "store" : (exm_memread ? "load" : "alu");
    $display("txn %s addr=%h rd=%0d lat=%0d wb_alu=%h wb_rdata=%h err=%0b",
             kind, exm_alu_result, exm_rd, lat, wb_alu_result, wb_readdata, mem_err);
  endtask

  initial begin
    int s0, r0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;
    model_clear();
    @(posedge clk); #1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_mem_req", 64'(mem_bus.mem_req), 64'd0);
    chk("rst_mem_err", 64'(mem_err), 64'd0);
    chk("rst_wb_regwrite", 64'(wb_regwrite), 64'd0);
    chk("rst_wb_alu", wb_alu_result, 64'd0);

    // ALU op passes straight through
    s0 = stall_seen;
    set_instr(0, 0, 0, 0, 0, 0, 1, 64'h2A, 0, 0, 5);
    run(0, 0, 0);
    chk("alu_wb_alu", wb_alu_result, 64'h2A);
    chk("alu_wb_rd", 64'(wb_rd), 64'd5);
    chk("alu_wb_regwrite", 64'(wb_regwrite), 64'd1);
    chk("alu_stall_cycles", 64'(stall_seen - s0), 64'd0);

    // load, ack 3 cycles after mem_req
    s0 = stall_seen;
    set_instr(0, 0, 0, 1, 0, 1, 1, 64'h100, 0, 0, 7);
    run(4, 64'hDEAD, 0);
    chk("load_stall_cycles", 64'(stall_seen - s0), 64'd4);
    chk("load_wb_readdata", wb_readdata, 64'hDEAD);
    chk("load_wb_memtoreg", 64'(wb_memtoreg), 64'd1);
    chk("load_wb_rd", 64'(wb_rd), 64'd7);

    // store, ack after 1 cycle
    r0 = req_seen;
    store_dir = 1;
    set_instr(0, 0, 0, 0, 1, 0, 0, 64'h80, 64'h55, 0, 2);
    run(2, 0, 0);
    store_dir = 0;
    chk("store_req_cycles", 64'(req_seen - r0), 64'd2);
    chk("store_wb_regwrite", 64'(wb_regwrite), 64'd0);

    // beq / bne with zero=1
    set_instr(1, 0, 1, 0, 0, 0, 0, 0, 0, 64'h40, 0);
    #1;
    chk("beq_redirect", 64'(pc_redirect), 64'd1);
    chk("beq_target", pc_target, 64'h40);
    run(0, 0, 0);
    set_instr(1, 1, 1, 0, 0, 0, 0, 0, 0, 64'h40, 0);
    #1;
    chk("bne_redirect", 64'(pc_redirect), 64'd0);
    run(0, 0, 0);

    // load that never gets an ack
    s0 = stall_seen;
    set_instr(0, 0, 0, 1, 0, 1, 1, 64'h300, 0, 0, 9);
    run(1000, 0, 0);
    chk("tmo_err", 64'(mem_err), 64'd1);
    chk("tmo_wb_readdata", wb_readdata, 64'd0);
    chk("tmo_stall_cycles", 64'(stall_seen - s0), 64'(TMO));
    chk("tmo_req_released", 64'(mem_bus.mem_req), 64'd0);
    s0 = stall_seen;
    set_instr(0, 0, 0, 0, 0, 0, 1, 64'h77, 0, 0, 4);
    run(0, 0, 0);
    chk("post_tmo_alu", wb_alu_result, 64'h77);
    chk("post_tmo_stall", 64'(stall_seen - s0), 64'd0);

    // reset in the middle of an access, then a stale ack
    set_instr(0, 0, 0, 1, 0, 1, 1, 64'h200, 0, 0, 3);
    mem_bus.mem_ack = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 64'hBEEF;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("rstmid_mem_req", 64'(mem_bus.mem_req), 64'd0);
    chk("rstmid_stall", 64'(stall_o), 64'd0);
    chk("rstmid_wb_readdata", wb_readdata, 64'd0);
    chk("rstmid_wb_regwrite", 64'(wb_regwrite), 64'd0);
    chk("rstmid_wb_alu", wb_alu_result, 64'd0);
    chk("rstmid_err", 64'(mem_err), 64'd0);
    tick();
    chk("rstmid_req_after", 64'(mem_bus.mem_req), 64'd0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic mr, mw;
      mr = ($urandom_range(0, 9) < 3);
      mw = ($urandom_range(0, 9) < 2);
      set_instr($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                mr, mw, $urandom_range(0, 1), $urandom_range(0, 1),
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                5'($urandom_range(0, 31)));
      run($urandom_range(1, TMO + 2), {$urandom, $urandom}, 1);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
